// File: rtl/prog_inst_memory.sv
// prog_inst_memory: program instruction memory with power-up clear sweep, burst loading and 1-cycle fetch
//   clk, rstn                  : clock, synchronous active-low reset
//   pc, fetch_req, fetch_ready : fetch request handshake (byte address)
//   instruction, inst_valid    : registered fetch result, one-cycle valid pulse
//   fault                      : [0] misaligned, [1] out of range, qualified by inst_valid
//   load_valid/ready/addr/data/last : program-load write channel
//   load_err                   : sticky flag for out-of-range load writes
module prog_inst_memory #(
  parameter int          NUM_INST = 128,
  parameter logic [31:0] NOP_INST = 32'h00000013,
  localparam int         ADDR_W   = $clog2(NUM_INST)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [31:0]       pc,
  input  logic              fetch_req,
  output logic              fetch_ready,
  output logic [31:0]       instruction,
  output logic              inst_valid,
  output logic [1:0]        fault,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ADDR_W:0]   load_addr,
  input  logic [31:0]       load_data,
  input  logic              load_last,
  output logic              load_err
);
  typedef enum logic [1:0] {CLEAR, RUN, LOAD} state_t;
  state_t state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [31:0] mem [NUM_INST];
  logic load_acc, fetch_acc, mem_we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0] wdata;
  logic [1:0] fault_nxt;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= state == CLEAR ? cnt + 1'b1 : '0;
    end
  end
  // Loads win over fetches, so the memory never sees a same-word read and write
  always_comb begin
    state_nxt   = state;
    load_ready  = state != CLEAR;
    fetch_ready = state == RUN && !load_valid;
    load_acc    = load_valid && load_ready;
    fetch_acc   = fetch_req && fetch_ready;
    fault_nxt   = {|pc[31:ADDR_W+2], |pc[1:0]};
    mem_we      = state == CLEAR || (load_acc && !load_addr[ADDR_W]);
    waddr       = state == CLEAR ? cnt : load_addr[ADDR_W-1:0];
    wdata       = state == CLEAR ? '0 : load_data;
    if (state == CLEAR && cnt == ADDR_W'(NUM_INST - 1))
      state_nxt = RUN;
    else if (load_acc)
      state_nxt = load_last ? RUN : LOAD;
  end
  always_ff @(posedge clk) begin
    if (rstn && mem_we)
      mem[waddr] <= wdata;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      instruction <= '0;
      inst_valid  <= 1'b0;
      fault       <= 2'b00;
      load_err    <= 1'b0;
    end else begin
      inst_valid <= fetch_acc;
      if (fetch_acc) begin
        fault       <= fault_nxt;
        instruction <= |fault_nxt ? NOP_INST : mem[pc[ADDR_W+1:2]];
      end
      if (load_acc && load_addr[ADDR_W])
        load_err <= 1'b1;
    end
  end
endmodule
